// File: rtl/cpu_fetch_pkg.sv
// Shared state and opcode codes for the fetch stage and its neighbours.
// STATE_* are the 4-bit state codes that cpu_control emits.
// OP_* are the 8-bit opcodes that cpu_control decodes from IR.
package cpu_fetch_pkg;

  typedef enum logic [3:0] {
    STATE_FETCH_PC   = 4'd0,
    STATE_FETCH_INST = 4'd1,
    STATE_LOAD_ADDR  = 4'd2,
    STATE_RAM_A      = 4'd3,
    STATE_RAM_B      = 4'd4,
    STATE_STORE_A    = 4'd5,
    STATE_ALU_OP     = 4'd6,
    STATE_JUMP       = 4'd7,
    STATE_OUT_A      = 4'd8,
    STATE_NEXT       = 4'd9,
    STATE_HALT       = 4'd10
  } state_e;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_STA = 8'h04;
  localparam logic [7:0] OP_OUT = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h06;
  localparam logic [7:0] OP_JEZ = 8'h07;
  localparam logic [7:0] OP_JNZ = 8'h08;
  localparam logic [7:0] OP_HLT = 8'h09;

  // States in which the RAM is read through MAR.
  function automatic logic is_mem_rd(input logic [3:0] st);
    return (st == STATE_FETCH_INST) || (st == STATE_LOAD_ADDR) || (st == STATE_JUMP);
  endfunction

endpackage

// File: rtl/cpu_fetch_jump_cond.sv
// cpu_jump_cond: combinational branch-condition evaluator.
// Ports:
//   i_opcode  in  8  instruction register contents
//   i_zero    in  1  ALU zero flag
//   o_take    out 1  branch is taken
module cpu_jump_cond
  import cpu_fetch_pkg::*;
(
  input  logic [7:0] i_opcode,
  input  logic       i_zero,
  output logic       o_take
);

  assign o_take = (i_opcode == OP_JMP) ||
                  ((i_opcode == OP_JEZ) &&  i_zero) ||
                  ((i_opcode == OP_JNZ) && !i_zero);

endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch / program counter stage ahead of cpu_control.
// Holds PC, MAR, IR and operand, reacts to the state code from cpu_control and
// hands back the opcode. Emits reset_cycle to restart cpu_control's cycle count.
// Ports:
//   clk          in   1       clock
//   reset_n      in   1       async active-low reset
//   state        in   4       STATE_* code from cpu_control
//   mem_data     in   DATA_W  RAM read data (combinational from mem_addr)
//   zero         in   1       ALU zero flag, sampled at the JUMP edge
//   mem_addr     out  ADDR_W  RAM address (MAR)
//   mem_rd       out  1       RAM read strobe
//   opcode       out  8       IR
//   operand      out  DATA_W  last operand byte
//   pc           out  ADDR_W  program counter
//   reset_cycle  out  1       one-clock cycle-restart pulse
//   halted       out  1       sticky halt flag
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        state,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              zero,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [7:0]        opcode,
  output logic [DATA_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  output logic              reset_cycle,
  output logic              halted
);

  logic [ADDR_W-1:0] r_pc, r_mar;
  logic [7:0]        r_ir;
  logic [DATA_W-1:0] r_operand;
  logic              r_reset_cycle, r_halted;
  // Cleared by reset; its first set edge produces the post-reset realign pulse.
  logic              r_boot;

  logic              w_take;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + ADDR_W'(1);

  cpu_jump_cond u_jump_cond (
    .i_opcode (r_ir),
    .i_zero   (zero),
    .o_take   (w_take)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= '0;
      r_mar         <= '0;
      r_ir          <= '0;
      r_operand     <= '0;
      r_reset_cycle <= 1'b0;
      r_halted      <= 1'b0;
      r_boot        <= 1'b0;
    end else begin
      r_boot <= 1'b1;
      // Pulse never repeats on back-to-back clocks, and never while halted.
      if (!r_boot)
        r_reset_cycle <= 1'b1;
      else
        r_reset_cycle <= !r_halted && (state == STATE_NEXT) && !r_reset_cycle;

      if (!r_halted) begin
        case (state)
          STATE_FETCH_PC:   r_mar <= r_pc;
          STATE_FETCH_INST: begin
            r_ir <= mem_data[7:0];
            r_pc <= w_pc_inc;
          end
          STATE_LOAD_ADDR: begin
            r_operand <= mem_data;
            r_mar     <= mem_data[ADDR_W-1:0];
            r_pc      <= w_pc_inc;
          end
          STATE_JUMP: begin
            r_operand <= mem_data;
            r_pc      <= w_take ? mem_data[ADDR_W-1:0] : w_pc_inc;
          end
          STATE_HALT:       r_halted <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign mem_addr    = r_mar;
  assign mem_rd      = is_mem_rd(state);
  assign opcode      = r_ir;
  assign operand     = r_operand;
  assign pc          = r_pc;
  assign reset_cycle = r_reset_cycle;
  assign halted      = r_halted;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: drives state codes against a small RAM model
// and checks hand-computed register values after each edge.
module tb_cpu_fetch;
  import cpu_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] state;
  logic [7:0] mem_data;
  logic       zero;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] pc;
  logic       reset_cycle;
  logic       halted;

  logic [7:0] ram [0:255];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_data = ram[mem_addr];

  cpu_fetch #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .state       (state),
    .mem_data    (mem_data),
    .zero        (zero),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .opcode      (opcode),
    .operand     (operand),
    .pc          (pc),
    .reset_cycle (reset_cycle),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a state code, take one edge, sample 1 time unit later.
  task automatic step(input logic [3:0] st);
    state = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    state   = STATE_OUT_A;
    zero    = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h00] = OP_LDA; ram[8'h01] = 8'h0E;
    ram[8'h02] = OP_JEZ; ram[8'h03] = 8'h20;
    ram[8'h20] = OP_JMP; ram[8'h21] = 8'h04;
    ram[8'h04] = OP_JEZ; ram[8'h05] = 8'h20;
    ram[8'h06] = OP_JNZ; ram[8'h07] = 8'h40;
    ram[8'h40] = OP_JMP; ram[8'h41] = 8'hFE;
    ram[8'hFE] = OP_LDA; ram[8'hFF] = 8'h37;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_operand", operand, 0);
    chk("rst_mar", mem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rc", reset_cycle, 0);
    chk("rst_mem_rd_idle", mem_rd, 0);
    reset_n = 1'b1;
    step(STATE_OUT_A); chk("boot_rc_hi", reset_cycle, 1);
    step(STATE_OUT_A); chk("boot_rc_lo", reset_cycle, 0);
    chk("boot_pc", pc, 0);

    // Fetch LDA 0x0E
    step(STATE_FETCH_PC);
    chk("fp_mar", mem_addr, 0);
    state = STATE_FETCH_INST;
    #1 chk("mem_rd_fi", mem_rd, 1);
    @(posedge clk); #1;
    chk("fi_opcode", opcode, OP_LDA);
    chk("fi_pc", pc, 1);
    step(STATE_FETCH_PC);
    step(STATE_LOAD_ADDR);
    chk("la_opcode", opcode, OP_LDA);
    chk("la_operand", operand, 8'h0E);
    chk("la_mar", mem_addr, 8'h0E);
    chk("la_pc", pc, 2);

    // Held NEXT: pulse, low, pulse
    step(STATE_NEXT);  chk("next_rc1", reset_cycle, 1);
    step(STATE_NEXT);  chk("next_rc2", reset_cycle, 0);
    step(STATE_NEXT);  chk("next_rc3", reset_cycle, 1);
    step(STATE_OUT_A); chk("next_rc4", reset_cycle, 0);
    chk("next_pc", pc, 2);
    chk("next_mar", mem_addr, 8'h0E);

    // JEZ taken with zero=1
    zero = 1'b1;
    step(STATE_FETCH_PC); step(STATE_FETCH_INST); step(STATE_FETCH_PC);
    step(STATE_JUMP);
    chk("jez_t_pc", pc, 8'h20);
    chk("jez_t_operand", operand, 8'h20);
    chk("jez_t_mar", mem_addr, 8'h03);
    zero = 1'b0;
    // JMP taken with zero=0
    step(STATE_FETCH_PC); step(STATE_FETCH_INST); step(STATE_FETCH_PC);
    step(STATE_JUMP);
    chk("jmp_pc", pc, 8'h04);
    // JEZ not taken from pc=5
    step(STATE_FETCH_PC); step(STATE_FETCH_INST);
    chk("jez_nt_pc5", pc, 8'h05);
    step(STATE_FETCH_PC); step(STATE_JUMP);
    chk("jez_nt_pc", pc, 8'h06);
    chk("jez_nt_mar", mem_addr, 8'h05);
    // JNZ taken with zero=0
    step(STATE_FETCH_PC); step(STATE_FETCH_INST); step(STATE_FETCH_PC);
    step(STATE_JUMP);
    chk("jnz_pc", pc, 8'h40);

    // Wrap on LOAD_ADDR at pc=0xFF
    step(STATE_FETCH_PC); step(STATE_FETCH_INST); step(STATE_FETCH_PC);
    step(STATE_JUMP);
    chk("to_fe_pc", pc, 8'hFE);
    step(STATE_FETCH_PC); step(STATE_FETCH_INST);
    chk("pc_ff", pc, 8'hFF);
    step(STATE_FETCH_PC); step(STATE_LOAD_ADDR);
    chk("wrap_la_pc", pc, 8'h00);
    chk("wrap_la_mar", mem_addr, 8'h37);
    chk("wrap_la_operand", operand, 8'h37);

    // Wrap on FETCH_INST at pc=0xFF
    ram[8'h00] = OP_JMP; ram[8'h01] = 8'hFF; ram[8'hFF] = OP_HLT;
    step(STATE_FETCH_PC); step(STATE_FETCH_INST); step(STATE_FETCH_PC);
    step(STATE_JUMP);
    chk("to_ff_pc", pc, 8'hFF);
    step(STATE_FETCH_PC); step(STATE_FETCH_INST);
    chk("wrap_fi_pc", pc, 8'h00);
    chk("wrap_fi_opcode", opcode, OP_HLT);

    // Halt freezes everything and suppresses reset_cycle
    step(STATE_HALT);
    chk("halt_set", halted, 1);
    for (int i = 0; i < 10; i++) begin
      step((i % 2) ? STATE_NEXT : STATE_FETCH_INST);
      chk("halt_rc", reset_cycle, 0);
    end
    step(STATE_JUMP); step(STATE_LOAD_ADDR); step(STATE_FETCH_PC);
    chk("halt_pc", pc, 8'h00);
    chk("halt_opcode", opcode, OP_HLT);
    chk("halt_mar", mem_addr, 8'hFF);
    chk("halt_operand", operand, 8'hFF);
    chk("halt_sticky", halted, 1);
    state = STATE_OUT_A;
    reset_n = 1'b0;
    #1 chk("halt_clr", halted, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(STATE_OUT_A); chk("halt_boot_rc_hi", reset_cycle, 1);
    step(STATE_OUT_A); chk("halt_boot_rc_lo", reset_cycle, 0);

    // Mid-instruction async reset
    step(STATE_FETCH_PC); step(STATE_FETCH_INST);
    chk("mid_pc_pre", pc, 8'h01);
    chk("mid_opcode_pre", opcode, OP_JMP);
    state = STATE_LOAD_ADDR;
    #3 reset_n = 1'b0;
    #1;
    chk("mid_pc_async", pc, 0);
    chk("mid_opcode_async", opcode, 0);
    chk("mid_mar_async", mem_addr, 0);
    @(posedge clk); #1;
    chk("mid_pc_held", pc, 0);
    state = STATE_OUT_A;
    reset_n = 1'b1;
    step(STATE_OUT_A); chk("mid_rc_hi", reset_cycle, 1);
    step(STATE_OUT_A); chk("mid_rc_lo1", reset_cycle, 0);
    step(STATE_OUT_A); chk("mid_rc_lo2", reset_cycle, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
